uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one tx_module between NUM_REQ byte requesters. It accepts one byte per grant over a valid/ready handshake and latches the byte with the global frame configuration. It issues a single-cycle tx_start, waits for tx_done, then enforces a programmable inter-frame gap before the next grant. It sits between the requester-side logic and tx_module, and it owns tx_en, tx_start, tx_conf and tx_data.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
MAX_UART_DATA_W, 8, byte width presented to tx_module.
TOTAL_CONF_W, 5, width of tx_conf: {data[1:0], stop[1:0], parity}. Opaque to this block.
GAP_W, 8, width of the inter-frame gap count input.
TIMEOUT_W, 16, width of the watchdog counter.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
enable_i  in  1  scheduler enable; gates new grants only.
conf_i  in  TOTAL_CONF_W  frame configuration; sampled at grant.
gap_i  in  GAP_W  idle cycles between frames.
req_valid_i  in  NUM_REQ  per-requester byte valid.
req_data_i  in  NUM_REQ*MAX_UART_DATA_W  packed bytes; requester k occupies slice k.
req_ready_o  out  NUM_REQ  one-hot, single-cycle accept.
req_sent_o  out  NUM_REQ  one-hot, single-cycle frame-complete pulse to the owner.
grant_id_o  out  $clog2(NUM_REQ)  index of the current/last granted requester.
tx_en_o  out  1  to tx_module tx_en_i.
tx_start_o  out  1  to tx_module tx_start_i.
tx_conf_o  out  TOTAL_CONF_W  to tx_module tx_conf_i.
tx_data_o  out  MAX_UART_DATA_W  to tx_module tx_data_i.
tx_done_i  in  1  from tx_module tx_done_o.
tx_busy_i  in  1  from tx_module tx_busy_o.
busy_o  out  1  high in any state other than IDLE.
timeout_o  out  1  sticky watchdog error flag.

Behaviour:
- Reset (async assert, sync deassert handled externally): all outputs 0; state IDLE; round-robin pointer 0; gap and watchdog counters 0; timeout_o 0.
- All outputs are registered.
- tx_en_o: equals enable_i delayed by one cycle. It is forced high while the state is START or WAIT_DONE, so a frame in flight is never cut off.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE: grant occurs when enable_i=1, |req_valid_i=1 and tx_busy_i=0.
  - Winner is the first valid index searching upward from the pointer, with wrap.
  - In the grant cycle: req_ready_o[winner]=1 (next edge completes the handshake); the winner's data is latched into tx_data_o; conf_i is latched into tx_conf_o; grant_id_o is set to winner; pointer is set to (winner+1) mod NUM_REQ.
  - Next state: START.
- START: tx_start_o=1 for exactly one cycle. tx_data_o and tx_conf_o are held stable until the next grant. Next state: WAIT_DONE.
- WAIT_DONE:
  - Watchdog counts up from 0.
  - On tx_done_i=1: req_sent_o[grant_id_o] pulses for one cycle; next state is GAP, or IDLE if gap_i==0.
  - If the watchdog reaches all-ones before tx_done_i: timeout_o is set; no req_sent_o pulse; next state is GAP/IDLE by the same rule.
  - tx_done_i and watchdog saturation in the same cycle: done wins; timeout_o is not set.
- GAP: the counter loads gap_i-1 on entry and decrements. Leave to IDLE when it reaches 0. Exactly gap_i cycles are spent in GAP.
- tx_done_i outside WAIT_DONE is ignored.
- tx_busy_i=1 in IDLE blocks grants. This covers tx_module still finishing from a prior enable.
- enable_i deasserted in START, WAIT_DONE or GAP: the current frame and gap complete normally; no new grant follows.
- A requester dropping req_valid_i before its grant simply loses arbitration. A requester holding valid keeps being served fairly: at most NUM_REQ-1 other frames occur between two of its frames.
- conf_i and gap_i changes only take effect at the next grant or GAP entry.
- timeout_o clears only on reset.
- Back-to-back throughput: with gap_i=0 there is one IDLE cycle between tx_done_i and the next tx_start_o grant cycle.

Test Plan:
1. Single requester 0 sends 8'hAA with conf 5'b11000, gap 0, connected to tx_module. Required: req_ready_o=4'b0001 for one cycle; tx_start_o one cycle later; tx_data_o=8'hAA, tx_conf_o=5'b11000; after the frame, req_sent_o=4'b0001 once; busy_o returns to 0.
2. All four requesters valid with bytes 8'h10/8'h21/8'h32/8'h43, gap 2. Required: grant order 0,1,2,3,0 (pointer wrap); exactly 2 GAP cycles between each tx_done_i and the next IDLE.
3. Fairness: requester 1 continuously valid, requester 3 valid from start. Required: grants alternate 1,3,1,3 with no starvation.
4. Stub tx_module that never asserts tx_done_i, TIMEOUT_W=4. Required: timeout_o rises 15 cycles after entering WAIT_DONE; no req_sent_o pulse; FSM returns to IDLE and serves the next request.
5. enable_i dropped one cycle after tx_start_o. Required: tx_en_o stays 1 until tx_done_i; req_sent_o still pulses; no further grant while enable_i=0, even with req_valid_i=4'b1111.
6. rst_ni asserted mid-WAIT_DONE. Required: all outputs are immediately 0 and the pointer is 0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// ============================================================================
// uart_tx_scheduler_if -- requester and tx_module side signals of the scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_tx_scheduler_if #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int GAP_W           = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                                 enable_i;
  logic [TOTAL_CONF_W-1:0]              conf_i;
  logic [GAP_W-1:0]                     gap_i;
  logic [NUM_REQ-1:0]                   req_valid_i;
  logic [NUM_REQ*MAX_UART_DATA_W-1:0]   req_data_i;
  logic [NUM_REQ-1:0]                   req_ready_o;
  logic [NUM_REQ-1:0]                   req_sent_o;
  logic [ID_W-1:0]                      grant_id_o;
  logic                                 tx_en_o;
  logic                                 tx_start_o;
  logic [TOTAL_CONF_W-1:0]              tx_conf_o;
  logic [MAX_UART_DATA_W-1:0]           tx_data_o;
  logic                                 tx_done_i;
  logic                                 tx_busy_i;
  logic                                 busy_o;
  logic                                 timeout_o;

  // The scheduler itself is the master.
  modport master (
    input  enable_i, conf_i, gap_i, req_valid_i, req_data_i, tx_done_i, tx_busy_i,
    output req_ready_o, req_sent_o, grant_id_o, tx_en_o, tx_start_o, tx_conf_o,
           tx_data_o, busy_o, timeout_o
  );

  modport slave (
    output enable_i, conf_i, gap_i, req_valid_i, req_data_i, tx_done_i, tx_busy_i,
    input  req_ready_o, req_sent_o, grant_id_o, tx_en_o, tx_start_o, tx_conf_o,
           tx_data_o, busy_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler -- round-robin sharing of one tx_module among NUM_REQ byte sources
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int GAP_W           = 8,
  parameter int TIMEOUT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_tx_scheduler_if.master  bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [ID_W-1:0]            grant_id_q, grant_id_d;
  logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [TIMEOUT_W-1:0]       wd_q, wd_d;
  logic [NUM_REQ-1:0]         req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]         req_sent_q, req_sent_d;
  logic                       tx_en_q, tx_en_d;
  logic                       tx_start_q, tx_start_d;
  logic [TOTAL_CONF_W-1:0]    tx_conf_q, tx_conf_d;
  logic [MAX_UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                       busy_q, busy_d;
  logic                       timeout_q, timeout_d;

  logic                       arb_found;
  logic                       arb_hi_found;
  logic [ID_W-1:0]            arb_hi_idx;
  logic [ID_W-1:0]            arb_lo_idx;
  logic [ID_W-1:0]            arb_winner;
  logic [MAX_UART_DATA_W-1:0] win_data;
  logic                       frame_end;

  // Lowest valid index at/above the pointer wins; otherwise the lowest valid index overall.
  always_comb begin
    arb_found    = 1'b0;
    arb_hi_found = 1'b0;
    arb_hi_idx   = '0;
    arb_lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[k]) begin
        arb_found  = 1'b1;
        arb_lo_idx = ID_W'(k);
        if (ID_W'(k) >= ptr_q) begin
          arb_hi_found = 1'b1;
          arb_hi_idx   = ID_W'(k);
        end
      end
    end
    arb_winner = arb_hi_found ? arb_hi_idx : arb_lo_idx;
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == arb_winner) begin
        win_data = bus.req_data_i[k*MAX_UART_DATA_W +: MAX_UART_DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    gap_cnt_d   = gap_cnt_q;
    wd_d        = wd_q;
    req_ready_d = '0;
    req_sent_d  = '0;
    tx_start_d  = 1'b0;
    tx_conf_d   = tx_conf_q;
    tx_data_d   = tx_data_q;
    timeout_d   = timeout_q;
    frame_end   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i && arb_found && !bus.tx_busy_i) begin
          req_ready_d = NUM_REQ'(1) << arb_winner;
          tx_data_d   = win_data;
          tx_conf_d   = bus.conf_i;
          grant_id_d  = arb_winner;
          ptr_d       = (arb_winner == ID_W'(NUM_REQ - 1)) ? '0 : arb_winner + ID_W'(1);
          state_d     = ST_START;
        end
      end
      ST_START: begin
        tx_start_d = 1'b1;
        wd_d       = '0;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        // A done arriving on the saturation cycle still counts as a good frame.
        if (bus.tx_done_i) begin
          req_sent_d = NUM_REQ'(1) << grant_id_q;
          frame_end  = 1'b1;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          frame_end = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      if (bus.gap_i == '0) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_GAP;
        gap_cnt_d = bus.gap_i - GAP_W'(1);
      end
    end
  end

  // tx_en is held high while a frame is in flight so enable_i cannot cut it off.
  assign tx_en_d = bus.enable_i || (state_d == ST_START) || (state_d == ST_WAIT_DONE);
  assign busy_d  = (state_d != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      gap_cnt_q   <= '0;
      wd_q        <= '0;
      req_ready_q <= '0;
      req_sent_q  <= '0;
      tx_en_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_conf_q   <= '0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      gap_cnt_q   <= gap_cnt_d;
      wd_q        <= wd_d;
      req_ready_q <= req_ready_d;
      req_sent_q  <= req_sent_d;
      tx_en_q     <= tx_en_d;
      tx_start_q  <= tx_start_d;
      tx_conf_q   <= tx_conf_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.req_sent_o  = req_sent_q;
  assign bus.grant_id_o  = grant_id_q;
  assign bus.tx_en_o     = tx_en_q;
  assign bus.tx_start_o  = tx_start_q;
  assign bus.tx_conf_o   = tx_conf_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = timeout_q;

endmodule

`default_nettype wire
